// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a FIFO: pops one word when idle and
// serialises it as start / DBIT data bits LSB-first / stop.
module fifo_uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 54
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_dout,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int BW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int SW = $clog2(32);
  localparam int NW = $clog2(DBIT);

  localparam logic [BW-1:0] B_LAST   = BW'(DVSR - 1);
  localparam logic [SW-1:0] S_BITEND = SW'(15);
  localparam logic [SW-1:0] S_STPEND = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST   = NW'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          r_state;
  logic [BW-1:0]   r_baud;
  logic [SW-1:0]   r_s;
  logic [NW-1:0]   r_n;
  logic [DBIT-1:0] r_sh;
  logic            r_tx;

  state_t          w_state_nxt;
  logic [BW-1:0]   w_baud_nxt;
  logic [SW-1:0]   w_s_nxt;
  logic [NW-1:0]   w_n_nxt;
  logic [DBIT-1:0] w_sh_nxt;
  logic            w_tx_nxt;
  logic            w_tick;
  logic            w_pop;
  logic            w_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_s     <= '0;
      r_n     <= '0;
      r_sh    <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_sh    <= w_sh_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // tx is loaded with the level of the state being entered
  always_comb begin
    w_tick      = (r_state != IDLE) && (r_baud == B_LAST);
    w_pop       = (r_state == IDLE) && !fifo_empty && !reset;
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_sh_nxt    = r_sh;
    w_tx_nxt    = r_tx;
    w_done      = 1'b0;

    if (r_state != IDLE) begin
      w_baud_nxt = w_tick ? '0 : r_baud + 1'b1;
    end
    if (w_tick) begin
      w_s_nxt = r_s + 1'b1;
    end

    unique case (r_state)
      IDLE: begin
        w_baud_nxt = '0;
        w_s_nxt    = '0;
        w_tx_nxt   = 1'b1;
        if (w_pop) begin
          w_state_nxt = START;
          w_sh_nxt    = fifo_dout;
          w_tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (w_tick && (r_s == S_BITEND)) begin
          w_state_nxt = DATA;
          w_s_nxt     = '0;
          w_n_nxt     = '0;
          w_tx_nxt    = r_sh[0];
        end
      end
      DATA: begin
        if (w_tick && (r_s == S_BITEND)) begin
          w_s_nxt  = '0;
          w_sh_nxt = r_sh >> 1;
          if (r_n == N_LAST) begin
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_n_nxt  = r_n + 1'b1;
            w_tx_nxt = r_sh[1];
          end
        end
      end
      STOP: begin
        if (w_tick && (r_s == S_STPEND)) begin
          w_state_nxt = IDLE;
          w_s_nxt     = '0;
          w_done      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign fifo_rd      = w_pop;
  assign tx           = r_tx;
  assign tx_busy      = (r_state != IDLE);
  assign tx_done_tick = w_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model, frame checker against
// an arithmetic line-level model, three stop-length variants.
module tb_fifo_uart_tx;

  localparam int D  = 4;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] fq[$];
  logic       push;
  logic [7:0] push_d;
  logic       fe0 = 1'b1;
  logic [7:0] fh0 = 8'h00;
  logic [7:0] rnd = 8'h00;
  logic       scr;
  logic [7:0] dout0;
  logic       rd0, tx0, busy0, done0;

  logic       ld1, ld2;
  logic       e1 = 1'b1;
  logic       e2 = 1'b1;
  logic [7:0] d1, d2;
  logic       rd1, tx1, busy1, done1;
  logic       rd2, tx2, busy2, done2;

  int   sel;
  logic m_rd, m_tx, m_busy, m_done;

  assign dout0 = scr ? rnd : fh0;

  fifo_uart_tx #(.DBIT(DB), .SB_TICK(16), .DVSR(D)) u0 (
    .clk(clk), .reset(rst), .fifo_empty(fe0), .fifo_dout(dout0),
    .fifo_rd(rd0), .tx(tx0), .tx_busy(busy0), .tx_done_tick(done0));

  fifo_uart_tx #(.DBIT(DB), .SB_TICK(32), .DVSR(D)) u1 (
    .clk(clk), .reset(rst), .fifo_empty(e1), .fifo_dout(d1),
    .fifo_rd(rd1), .tx(tx1), .tx_busy(busy1), .tx_done_tick(done1));

  fifo_uart_tx #(.DBIT(DB), .SB_TICK(24), .DVSR(D)) u2 (
    .clk(clk), .reset(rst), .fifo_empty(e2), .fifo_dout(d2),
    .fifo_rd(rd2), .tx(tx2), .tx_busy(busy2), .tx_done_tick(done2));

  // FIFO behaviour: pop on rd, push on request, flags registered
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd0 && fq.size() > 0) void'(fq.pop_front());
    if (push) fq.push_back(push_d);
    fe0 <= (fq.size() == 0);
    fh0 <= (fq.size() != 0) ? fq[0] : 8'h00;
    rnd <= 8'($urandom);
    if (ld1) e1 <= 1'b0;
    else if (rd1) e1 <= 1'b1;
    if (ld2) e2 <= 1'b0;
    else if (rd2) e2 <= 1'b1;
  end

  always_comb begin
    m_rd = rd0; m_tx = tx0; m_busy = busy0; m_done = done0;
    if (sel == 1) begin
      m_rd = rd1; m_tx = tx1; m_busy = busy1; m_done = done1;
    end else if (sel == 2) begin
      m_rd = rd2; m_tx = tx2; m_busy = busy2; m_done = done2;
    end
  end

  task automatic chk(input logic [31:0] got, input logic [31:0] exp,
                     input string tag);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Line level c cycles after the pop cycle
  function automatic logic exp_tx(logic [7:0] w, int c, int bitc);
    if (c <= bitc) return 1'b0;
    if (c <= (1 + DB) * bitc) return w[(c - 1) / bitc - 1];
    return 1'b1;
  endfunction

  task automatic push_w(input logic [7:0] w);
    push = 1'b1;
    push_d = w;
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic frame(input int s_sel, input logic [7:0] w, input int sb,
                       input bit iso, input string tag, output int pc);
    int bitc, tdone, k, txerr, busyerr, rderr, ndone, doneat, stoplen;
    logic [7:0] dec;
    bitc = 16 * D;
    tdone = (1 + DB) * bitc + sb * D;
    txerr = 0; busyerr = 0; rderr = 0; ndone = 0;
    doneat = -1; stoplen = 0; dec = 8'h00;
    sel = s_sel;
    #1;
    k = 0;
    while (!m_rd && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk(32'(m_rd), 1, {tag, "_pop"});
    pc = cyc;
    for (int c = 1; c <= tdone + 1; c++) begin
      @(negedge clk);
      if (iso && c == 1) scr = 1'b1;
      if (m_tx !== exp_tx(w, c, bitc)) txerr++;
      if (m_busy !== (c <= tdone)) busyerr++;
      if (m_rd && c <= tdone) rderr++;
      if (m_done) begin
        ndone++;
        if (doneat < 0) doneat = c;
      end
      if (c > (1 + DB) * bitc && c <= tdone && m_tx === 1'b1) stoplen++;
      for (int i = 0; i < DB; i++)
        if (c == (i + 1) * bitc + bitc / 2) dec[i] = m_tx;
    end
    scr = 1'b0;
    chk(txerr, 0, {tag, "_wave"});
    chk(32'(dec), 32'(w), {tag, "_data"});
    chk(doneat, tdone, {tag, "_done_at"});
    chk(ndone, 1, {tag, "_done_cnt"});
    chk(busyerr, 0, {tag, "_busy"});
    chk(rderr, 0, {tag, "_extra_rd"});
    chk(stoplen, sb * D, {tag, "_stop_len"});
  endtask

  initial begin
    int p1, p2, p3, nrd, nlow;
    logic [7:0] rw[4];
    int rp[4];
    push = 1'b0; push_d = 8'h00; ld1 = 1'b0; ld2 = 1'b0;
    scr = 1'b0; sel = 0; d1 = 8'h81; d2 = 8'h81;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk(32'(tx0), 1, "rst_tx");
    chk(32'(busy0), 0, "rst_busy");
    chk(32'(done0), 0, "rst_done");
    chk(32'(rd0), 0, "rst_rd");
    chk(32'(tx1), 1, "rst_tx1");
    rst = 1'b0;

    push_w(8'hA5);
    frame(0, 8'hA5, 16, 1'b0, "a5", p1);

    rst = 1'b1;
    push_w(8'h00);
    push_w(8'hFF);
    push_w(8'h3C);
    chk(32'(rd0), 0, "rst_gate");
    rst = 1'b0;
    frame(0, 8'h00, 16, 1'b0, "b0", p1);
    frame(0, 8'hFF, 16, 1'b0, "b1", p2);
    frame(0, 8'h3C, 16, 1'b0, "b2", p3);
    chk(p2 - p1, 641, "gap1");
    chk(p3 - p2, 641, "gap2");
    chk(32'(fe0), 1, "b2b_empty");
    chk(32'(rd0), 0, "b2b_no_rd");

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rw[i] = 8'($urandom);
      push_w(rw[i]);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      frame(0, rw[i], 16, 1'b0, $sformatf("rnd%0d", i), rp[i]);
    for (int i = 1; i < 4; i++)
      chk(rp[i] - rp[i-1], 641, $sformatf("rnd_gap%0d", i));

    ld1 = 1'b1;
    @(negedge clk);
    ld1 = 1'b0;
    frame(1, 8'h81, 32, 1'b0, "sb32", p1);
    ld2 = 1'b1;
    @(negedge clk);
    ld2 = 1'b0;
    frame(2, 8'h81, 24, 1'b0, "sb24", p1);
    sel = 0;

    rst = 1'b1;
    push_w(8'h55);
    push_w(8'h33);
    rst = 1'b0;
    #1;
    chk(32'(rd0), 1, "mid_pop");
    repeat (280) @(negedge clk);
    chk(32'(tx0), 0, "mid_bit3");
    rst = 1'b1;
    @(negedge clk);
    chk(32'(tx0), 1, "mid_rst_tx");
    chk(32'(busy0), 0, "mid_rst_busy");
    chk(32'(done0), 0, "mid_rst_done");
    chk(32'(rd0), 0, "mid_rst_rd");
    rst = 1'b0;
    #1;
    chk(32'(rd0), 1, "mid_repop");
    chk(32'(dout0), 32'h33, "mid_next");
    frame(0, 8'h33, 16, 1'b0, "after_rst", p1);

    nrd = 0; nlow = 0;
    repeat (1000) begin
      @(negedge clk);
      if (rd0) nrd++;
      if (!tx0) nlow++;
    end
    chk(nrd, 0, "empty_rd");
    chk(nlow, 0, "empty_tx");
    rst = 1'b1;
    push_w(8'h5A);
    nrd = 0; nlow = 0;
    repeat (20) begin
      @(negedge clk);
      if (rd0) nrd++;
      if (!tx0) nlow++;
    end
    chk(nrd, 0, "rsthold_rd");
    chk(nlow, 0, "rsthold_tx");
    rst = 1'b0;
    frame(0, 8'h5A, 16, 1'b0, "drain", p1);

    push_w(8'h96);
    frame(0, 8'h96, 16, 1'b1, "iso", p1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
